// File: rtl/hamming_link_sched.sv
// Two-requester round-robin scheduler for a shared serial bit/strobe Hamming
// link. The granted word is sent LSB-first, one strobe per bit, then the
// scheduler waits for the downstream done flag. The corrected word is returned
// tagged with the requester id, or a zero word with an error flag on timeout.
module hamming_link_sched #(
   parameter int DATA_W  = 4,
   parameter int RSP_W   = 4,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              bit_out,
   output logic              strobe_out,
   input  logic              done_in,
   input  logic [RSP_W-1:0]  rsp_in,
   output logic              rsp_valid,
   output logic [RSP_W-1:0]  rsp_data,
   output logic              rsp_id,
   output logic              rsp_err,
   output logic              busy
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0]     bit_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [TW-1:0]     tmo_cnt;
   logic              cur_id;
   logic              last_grant;
   logic              sel1;
   logic              accept;
   logic [DATA_W-1:0] acc_word;

   // Round-robin selection: a lone requester wins; on a tie, the one not served last wins.
   always_comb begin
      sel1       = req1_valid & (~req0_valid | ~last_grant);
      req0_ready = (state == S_IDLE) & req0_valid & ~sel1;
      req1_ready = (state == S_IDLE) & sel1;
      accept     = req0_ready | req1_ready;
      acc_word   = sel1 ? req1_data : req0_data;
   end

   // Scheduler FSM; outputs are registered on the transition into each state,
   // so shreg always holds the bits still to be sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         tmo_cnt    <= '0;
         cur_id     <= 1'b0;
         last_grant <= 1'b1;
         bit_out    <= 1'b0;
         strobe_out <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state      <= S_SHIFT;
                  bit_out    <= acc_word[0];
                  shreg      <= acc_word >> 1;
                  strobe_out <= 1'b1;
                  bit_cnt    <= BW'(1);
                  cur_id     <= sel1;
                  last_grant <= sel1;
                  busy       <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (GAP > 0) begin
                  state      <= S_GAP;
                  strobe_out <= 1'b0;
                  gap_cnt    <= '0;
               end else if (bit_cnt == BIT_LAST) begin
                  state      <= S_WAIT;
                  strobe_out <= 1'b0;
                  tmo_cnt    <= '0;
               end else begin
                  strobe_out <= 1'b1;
                  bit_out    <= shreg[0];
                  shreg      <= shreg >> 1;
                  bit_cnt    <= bit_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (bit_cnt == BIT_LAST) begin
                     state   <= S_WAIT;
                     tmo_cnt <= '0;
                  end else begin
                     state      <= S_SHIFT;
                     strobe_out <= 1'b1;
                     bit_out    <= shreg[0];
                     shreg      <= shreg >> 1;
                     bit_cnt    <= bit_cnt + 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               // A done seen in the same cycle as the timeout still wins.
               if (done_in) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= rsp_in;
                  rsp_err   <= 1'b0;
                  rsp_id    <= cur_id;
               end else if (tmo_cnt == TMO_LAST) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_id    <= cur_id;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_RESP: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               bit_cnt <= '0;
               gap_cnt <= '0;
               tmo_cnt <= '0;
            end
            default: begin
               state      <= S_IDLE;
               strobe_out <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/hamming_link_sched.md
Name: hamming_link_sched

Overview:
- Two-requester scheduler that shares one serial bit/strobe Hamming link (encoder → injector → corrector chain) between independent sources.
- Arbitrates round-robin, serializes the granted parallel word LSB-first onto bit_out/strobe_out, then waits for the downstream done flag.
- Captures the corrected word and returns it tagged with the requester id, with a timeout guard.

Parameters:
- DATA_W, 4, width of each request word and number of serialized bits.
- RSP_W, 4, width of the returned corrected word.
- GAP, 1, strobe-low cycles after each strobe-high cycle (0 = back-to-back strobes).
- TIMEOUT, 31, maximum WAIT cycles before aborting; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  DATA_W  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  DATA_W  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- bit_out  out  1  serial data to the link.
- strobe_out  out  1  serial strobe, one-cycle pulse per bit.
- done_in  in  1  downstream result valid (level or sticky).
- rsp_in  in  RSP_W  downstream corrected word.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  RSP_W  captured word; 0 on timeout.
- rsp_id  out  1  requester that owns the response.
- rsp_err  out  1  response caused by timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous and immediate, including mid-operation:
  - state = IDLE; strobe_out = 0, bit_out = 0.
  - rsp_valid, rsp_err, rsp_id, rsp_data = 0; busy = 0.
  - Shift register, bit counter and timeout counter = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - An in-flight word is discarded; no response is ever issued for it.
- req0_ready / req1_ready are combinational:
  - High only in IDLE, only for the selected requester, only while its valid is high.
  - Transfer occurs on valid & ready at the clock edge.
- Arbitration, evaluated in IDLE only:
  - Single valid requester: grant it.
  - Both valid: grant the one that is not last_grant.
  - last_grant updates on each accept.
- FSM states:
  - IDLE: on accept, load the word into the shift register, store id, go to SHIFT.
  - SHIFT (1 cycle): strobe_out = 1, bit_out = shreg[0]. Shift right, increment bit count. Go to GAP if GAP > 0, else next SHIFT, or WAIT after bit DATA_W.
  - GAP (GAP cycles): strobe_out = 0, bit_out holds its last value. Then go to SHIFT, or to WAIT after bit DATA_W.
  - WAIT: timeout counter increments each cycle.
    - done_in high: latch rsp_in, rsp_err = 0, go to RESP.
    - Counter reaching TIMEOUT with done_in low: rsp_data = 0, rsp_err = 1, go to RESP.
    - done_in and timeout in the same cycle: done wins.
  - RESP (1 cycle): rsp_valid = 1, rsp_id = stored id; then IDLE. Counters clear.
- Latency, DATA_W = 4, GAP = 1, accept at cycle 0:
  - strobe_out high at cycles 1, 3, 5, 7.
  - WAIT entered at cycle 9.
  - done_in already high → rsp_valid at cycle 10; IDLE at 11, where the next accept is possible.
- done_in is ignored outside WAIT. A sticky done_in is seen on the first WAIT cycle.
- Request changes while busy are ignored; no ready is asserted outside IDLE.
- All outputs except reqN_ready are registered.

Test Plan:
- Reset then req0_valid = 1, req0_data = 4'b1011, done_in pulses at cycle 12, rsp_in = 4'hB → strobes at 1/3/5/7 with bits 1,1,0,1; rsp_valid at 13, rsp_data = 4'hB, rsp_id = 0, rsp_err = 0.
- Both valid continuously, req0 = 4'h3, req1 = 4'hC, done_in tied 1, rsp_in echoes a constant → accept order 0,1,0,1; rsp_id alternates; req1_ready first high at cycle 11.
- req1 only, done_in never asserted, TIMEOUT = 31 → WAIT at 9, rsp_valid at 41 with rsp_err = 1, rsp_data = 0, rsp_id = 1; then returns to IDLE.
- GAP = 0, req0_data = 4'b0110 → strobe_out high at cycles 1–4 consecutively with bits 0,1,1,0; WAIT at 5.
- rst_n low at cycle 4 mid-serialization → strobe_out and busy drop immediately; no rsp_valid; after release, next accept grants req0 on a tie.
- done_in high during SHIFT then low before WAIT → ignored; a response occurs only on a later done_in or on timeout.
